// File: rtl/register_pkg.sv
// Shared defaults and the data-word type for the register block.
package register_pkg;

  localparam int          DEFAULT_WIDTH       = 32;
  // Held at the widest legal width so any WIDTH can take a slice of it.
  localparam logic [63:0] DEFAULT_RESET_VALUE = 64'h0;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/register_parity_gen.sv
// Even-parity generator: XOR reduction of a WIDTH-bit word, purely combinational.
module register_parity_gen #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  // Reduction XOR gives 1 when the word holds an odd number of ones.
  always_comb begin
    parity = ^data;
  end

endmodule

// File: rtl/register.sv
// Loadable WIDTH-bit register with asynchronous active-high reset.
// Optional feature: define REGISTER_PARITY_EN to add a registered
// data_parity output that tracks the parity of the stored word.
module register
  import register_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = DEFAULT_RESET_VALUE[WIDTH-1:0]
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             r_enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
`ifdef REGISTER_PARITY_EN
  ,
  output logic             data_parity
`endif
);

  // Stored word: reset wins over a load, otherwise load on enable or hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= RESET_VALUE;
    end else if (r_enable) begin
      data_out <= data_in;
    end
  end

`ifdef REGISTER_PARITY_EN
  logic parity_next;

  // Parity of the incoming word is computed ahead of the flop so that the
  // parity bit and the data word update on the same edge.
  register_parity_gen #(
    .WIDTH (WIDTH)
  ) u_parity_gen (
    .data   (data_in),
    .parity (parity_next)
  );

  // Parity flop shares the data word's reset and enable behaviour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_parity <= ^RESET_VALUE;
    end else if (r_enable) begin
      data_parity <= parity_next;
    end
  end
`endif

endmodule

// File: tb/tb_register.sv
// Scoreboard testbench for register: the stimulus process pushes the
// expected word after each step, a monitor process pops and compares.
// Honours REGISTER_PARITY_EN for the data_parity checks.
module tb_register;
  import register_pkg::*;

  typedef struct {
    word_t data;
    logic  par;
    string name;
  } exp_t;

  logic  clock;
  logic  reset;
  logic  r_enable;
  word_t data_in;
  word_t data_out;
`ifdef REGISTER_PARITY_EN
  logic  data_parity;
`endif

  exp_t sb_q[$];
  int   pushed;
  int   popped;
  int   n_checks;
  int   n_fail;

  register #(
    .WIDTH       (32),
    .RESET_VALUE (32'h0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .r_enable    (r_enable),
    .data_in     (data_in),
    .data_out    (data_out)
`ifdef REGISTER_PARITY_EN
    ,
    .data_parity (data_parity)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: whenever an expectation is pending, compare the live outputs.
  initial begin
    exp_t e;
    forever begin
      wait (pushed > popped);
      e = sb_q.pop_front();
      popped++;
      n_checks++;
      if (data_out !== e.data) begin
        n_fail++;
        $display("FAIL %s data_out: got 0x%08h, expected 0x%08h", e.name, data_out, e.data);
      end else begin
        $display("ok   %s data_out=0x%08h", e.name, data_out);
      end
`ifdef REGISTER_PARITY_EN
      n_checks++;
      if (data_parity !== e.par) begin
        n_fail++;
        $display("FAIL %s data_parity: got %b, expected %b", e.name, data_parity, e.par);
      end
`endif
    end
  end

  task automatic expect_out(input word_t val, input logic par, input string name);
    exp_t e;
    e.data = val;
    e.par  = par;
    e.name = name;
    sb_q.push_back(e);
    pushed++;
    #1;
  endtask

  // Advance past the next rising edge to a stable sampling point.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int guard;
    pushed   = 0;
    popped   = 0;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    r_enable = 1'b0;
    data_in  = 32'h0;

    // Reset asserted before the first edge must act at once.
    #2;
    reset = 1'b1;
    #1;
    expect_out(32'h0, 1'b0, "reset_async");
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out(32'h0, 1'b0, "reset_held");
    end

    // Release reset between edges, then load and hold.
    #2;
    reset    = 1'b0;
    r_enable = 1'b1;
    data_in  = 32'hA5A5A5A5;
    tick();
    expect_out(32'hA5A5A5A5, 1'b0, "load_a5");
    r_enable = 1'b0;
    data_in  = 32'hFFFF0000;
    tick();
    expect_out(32'hA5A5A5A5, 1'b0, "hold_1");
    data_in  = 32'h00000001;
    tick();
    expect_out(32'hA5A5A5A5, 1'b0, "hold_2");
    data_in  = 'x;
    tick();
    expect_out(32'hA5A5A5A5, 1'b0, "hold_x");

    // Overwrite then hold.
    r_enable = 1'b1;
    data_in  = 32'h5A5A5A5A;
    tick();
    expect_out(32'h5A5A5A5A, 1'b0, "load_5a");
    r_enable = 1'b0;
    data_in  = 32'h0;
    tick();
    expect_out(32'h5A5A5A5A, 1'b0, "hold_5a");

    // Mid-cycle reset clears before the next edge.
    #2;
    reset = 1'b1;
    #1;
    expect_out(32'h0, 1'b0, "mid_reset_async");
    tick();
    expect_out(32'h0, 1'b0, "mid_reset_held");
    #2;
    reset = 1'b0;
    tick();
    expect_out(32'h0, 1'b0, "post_reset_no_reappear");

    // Ignored data with enable low, and reset priority over enable.
    data_in = 32'h12345678;
    tick();
    expect_out(32'h0, 1'b0, "ignore_en0");
    reset    = 1'b1;
    r_enable = 1'b1;
    tick();
    expect_out(32'h0, 1'b0, "reset_over_enable");
    tick();
    expect_out(32'h0, 1'b0, "reset_over_enable_2");
    r_enable = 1'b0;
    #2;
    reset = 1'b0;
    tick();
    expect_out(32'h0, 1'b0, "after_priority");

    // First load after reset release, then back-to-back loads.
    r_enable = 1'b1;
    data_in  = 32'h11111111;
    tick();
    expect_out(32'h11111111, 1'b0, "b2b_1");
    data_in  = 32'h22222223;
    tick();
    expect_out(32'h22222223, 1'b1, "b2b_2");
    data_in  = 32'h00000001;
    tick();
    expect_out(32'h00000001, 1'b1, "par_one");
    data_in  = 32'hA5A5A5A5;
    tick();
    expect_out(32'hA5A5A5A5, 1'b0, "par_a5");
    data_in  = 32'h80000007;
    tick();
    expect_out(32'h80000007, 1'b0, "par_four_ones");
    data_in  = 32'hFFFFFFFE;
    tick();
    expect_out(32'hFFFFFFFE, 1'b1, "par_31_ones");
    r_enable = 1'b0;
    data_in  = 32'h0;
    tick();
    expect_out(32'hFFFFFFFE, 1'b1, "hold_last");

    // Drain the scoreboard within a bounded time.
    guard = 0;
    while (popped < pushed && guard < 100) begin
      #1;
      guard++;
    end
    n_checks++;
    if (popped != pushed) begin
      n_fail++;
      $display("FAIL drain: popped %0d, expected %0d", popped, pushed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
